// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for a 5-stage pipeline.
// Merges load-use stalls, ID-stage redirects and data-memory wait into one
// prioritised set of pipeline-register enables and flushes. A small FSM
// stretches redirects over several IF/ID flush cycles, a watchdog traps
// memory accesses that never complete, and two saturating counters record
// stall and redirect activity.
module pipeline_hazard_sequencer #(
    parameter int CNT_W            = 32,
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MEM_TIMEOUT      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             Jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IFWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             MEMWB_bubble,
    output logic             err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    // Watchdog counter only needs to reach MEM_TIMEOUT-1.
    localparam bit WD_EN   = (MEM_TIMEOUT != 0);
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [3:0] BUBBLE_LOAD = 4'(REDIRECT_BUBBLES - 1);

    logic [1:0]        state_reg, state_next;
    logic [3:0]        bubble_reg, bubble_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [1:0]        cnt_inc;   // [0] stall_cnt, [1] flush_cnt

    logic frozen;
    logic redirect;

    assign frozen   = mem_req & ~mem_ready;
    assign redirect = Branch | Jump;

    // State, bubble and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_RUN;
            bubble_reg <= '0;
            wait_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            bubble_reg <= bubble_next;
            wait_reg   <= wait_next;
        end
    end

    // Next-state logic: ERROR traps, a memory freeze holds everything but the
    // watchdog, FLUSH counts down its bubbles, RUN accepts stalls then redirects.
    always_comb begin
        state_next  = state_reg;
        bubble_next = bubble_reg;
        wait_next   = '0;
        cnt_inc     = 2'b00;
        if (state_reg == ST_ERROR) begin
            wait_next = wait_reg;
        end else if (frozen) begin
            cnt_inc[0] = 1'b1;
            if (WD_EN) begin
                wait_next = wait_reg + 1'b1;
                if (wait_reg == WAIT_W'(TO_LAST)) begin
                    state_next = ST_ERROR;
                end
            end
        end else if (state_reg == ST_FLUSH) begin
            if (bubble_reg <= 4'd1) begin
                state_next  = ST_RUN;
                bubble_next = '0;
            end else begin
                bubble_next = bubble_reg - 4'd1;
            end
        end else if (Stall) begin
            cnt_inc[0] = 1'b1;
        end else if (redirect) begin
            cnt_inc[1] = 1'b1;
            if (REDIRECT_BUBBLES > 1) begin
                state_next  = ST_FLUSH;
                bubble_next = BUBBLE_LOAD;
            end
        end
    end

    // Same-cycle pipeline enables and flushes in priority order.
    always_comb begin
        PCWrite      = 1'b1;
        IFWrite      = 1'b1;
        IDEXWrite    = 1'b1;
        EXMEMWrite   = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_flush   = 1'b0;
        MEMWB_bubble = 1'b0;
        if (!rst_n) begin
            PCWrite      = 1'b0;
            IFWrite      = 1'b0;
            IDEXWrite    = 1'b0;
            EXMEMWrite   = 1'b0;
            IFID_flush   = 1'b1;
            IDEX_flush   = 1'b1;
            MEMWB_bubble = 1'b1;
        end else if (state_reg == ST_ERROR) begin
            PCWrite    = 1'b0;
            IFWrite    = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
        end else if (frozen) begin
            PCWrite      = 1'b0;
            IFWrite      = 1'b0;
            IDEXWrite    = 1'b0;
            EXMEMWrite   = 1'b0;
            MEMWB_bubble = 1'b1;
        end else if (state_reg == ST_FLUSH) begin
            IFID_flush = 1'b1;
        end else if (Stall) begin
            PCWrite    = 1'b0;
            IFWrite    = 1'b0;
            IDEX_flush = 1'b1;
        end else if (redirect) begin
            IFID_flush = 1'b1;
        end
    end

    // Saturating performance counters, one per event class.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            logic [CNT_W-1:0] cnt_reg;
            // Count up on the event, sticking at all-ones.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = g_perf[0].cnt_reg;
    assign flush_cnt = g_perf[1].cnt_reg;
    assign state     = state_reg;
    assign err       = (state_reg == ST_ERROR);

endmodule
